// File: rtl/alpha_pipe_pkg.sv
// rtl/alpha_pipe_pkg.sv - shared stage encodings and counter sizing for pipe_skid_reg
package alpha_pipe_pkg;

  // Encoded as {s_v, m_v} so the state bits double as the stage flags.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } stage_state_t;

  function automatic int cnt_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// rtl/skid_stage.sv - one skid-buffered valid/ready stage with registered ready
module skid_stage
  import alpha_pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  stage_state_t     r_state;
  stage_state_t     w_next;
  logic [WIDTH-1:0] r_main_d;
  logic [WIDTH-1:0] r_skid_d;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  assign in_ready   = ~r_state[1];
  assign out_valid  = r_state[0];
  assign out_data   = r_main_d;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  always_comb begin
    w_next           = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_next         = ST_BUSY;
            w_load_main_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_next      = ST_FULL;
            w_load_skid = 1'b1;
          end else if (w_out_fire) begin
            w_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_next           = ST_BUSY;
            w_load_main_skid = 1'b1;
          end
        end
        default: w_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  // Data registers keep their contents on flush; only the valid flags are squashed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_main_d <= RESET_VALUE;
      r_skid_d <= RESET_VALUE;
    end else begin
      if (w_load_main_in) begin
        r_main_d <= in_data;
      end else if (w_load_main_skid) begin
        r_main_d <= r_skid_d;
      end
      if (w_load_skid) begin
        r_skid_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - chain of STAGES skid stages with flush and occupancy count
module pipe_skid_reg
  import alpha_pipe_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               STAGES      = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = cnt_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [STAGES:0]  w_valid;
  logic [STAGES:0]  w_ready;
  logic [WIDTH-1:0] w_data [STAGES+1];
  logic             w_in_fire;
  logic             w_out_fire;
  logic [CNT_W-1:0] r_count;

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = in_data;
  assign in_ready        = w_ready[0];
  assign out_valid       = w_valid[STAGES];
  assign out_data        = w_data[STAGES];
  assign w_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    skid_stage #(
      .WIDTH       (WIDTH),
      .RESET_VALUE (RESET_VALUE)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (w_valid[k]),
      .in_ready  (w_ready[k]),
      .in_data   (w_data[k]),
      .out_valid (w_valid[k+1]),
      .out_ready (w_ready[k+1]),
      .out_data  (w_data[k+1])
    );
  end

  assign w_in_fire  = in_valid & w_ready[0];
  assign w_out_fire = w_valid[STAGES] & out_ready;
  assign count      = r_count;

  // Occupancy tracks the boundary handshakes; internal stage moves do not change it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (flush) begin
      r_count <= '0;
    end else if (w_in_fire && !w_out_fire) begin
      r_count <= r_count + CNT_W'(1);
    end else if (!w_in_fire && w_out_fire) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - directed and scoreboard checks for pipe_skid_reg
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;

  logic        f2, iv2, ir2, ov2, or2;
  logic [31:0] id2, od2;
  logic [2:0]  cnt2;

  logic        f3, iv3, ir3, ov3, or3;
  logic [7:0]  id3, od3;
  logic [2:0]  cnt3;

  always #5 if (clk_en) clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .flush(f2), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .count(cnt2)
  );

  pipe_skid_reg #(.WIDTH(8), .STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .flush(f3), .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .count(cnt3)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    f2 = 0; iv2 = 0; or2 = 0; id2 = '0;
    f3 = 0; iv3 = 0; or3 = 0; id3 = '0;
    #3;
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL reset_ov2 got %b exp 0", ov2); end
    checks++; if (od2 !== 32'h0) begin errors++; $display("FAIL reset_od2 got %h exp 0", od2); end
    checks++; if (cnt2 !== 3'd0) begin errors++; $display("FAIL reset_cnt2 got %0d exp 0", cnt2); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL reset_ir2 got %b exp 1", ir2); end
    checks++; if (ov3 !== 1'b0) begin errors++; $display("FAIL reset_ov3 got %b exp 0", ov3); end
    checks++; if (od3 !== 8'h0) begin errors++; $display("FAIL reset_od3 got %h exp 0", od3); end
    checks++; if (cnt3 !== 3'd0) begin errors++; $display("FAIL reset_cnt3 got %0d exp 0", cnt3); end
    checks++; if (ir3 !== 1'b1) begin errors++; $display("FAIL reset_ir3 got %b exp 1", ir3); end
    clk_en = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

  task automatic test_stream();
    logic [31:0] din [3] = '{32'h11, 32'h22, 32'h33};
    logic        e_ov [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] e_od [5] = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
    logic [2:0]  e_cnt [5] = '{3'd1, 3'd2, 3'd2, 3'd1, 3'd0};
    int          peak = 0;
    or2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      iv2 = (i < 3);
      id2 = (i < 3) ? din[i] : 32'h0;
      step();
      if (int'(cnt2) > peak) peak = int'(cnt2);
      checks++; if (ov2 !== e_ov[i]) begin errors++; $display("FAIL stream_ov[%0d] got %b exp %b", i, ov2, e_ov[i]); end
      if (e_ov[i]) begin
        checks++; if (od2 !== e_od[i]) begin errors++; $display("FAIL stream_od[%0d] got %h exp %h", i, od2, e_od[i]); end
      end
      checks++; if (cnt2 !== e_cnt[i]) begin errors++; $display("FAIL stream_cnt[%0d] got %0d exp %0d", i, cnt2, e_cnt[i]); end
    end
    iv2 = 1'b0;
    checks++; if (peak != 2) begin errors++; $display("FAIL stream_peak got %0d exp 2", peak); end
  endtask

  task automatic test_capacity();
    int  idx = 1;
    int  n = 0;
    logic fire;
    or2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      iv2 = (idx <= 6);
      id2 = 32'(idx);
      fire = iv2 & ir2;
      step();
      if (fire) idx++;
    end
    iv2 = 1'b0;
    checks++; if (idx - 1 != 4) begin errors++; $display("FAIL cap_accepts got %0d exp 4", idx - 1); end
    checks++; if (cnt2 !== 3'd4) begin errors++; $display("FAIL cap_cnt got %0d exp 4", cnt2); end
    checks++; if (ir2 !== 1'b0) begin errors++; $display("FAIL cap_ir got %b exp 0", ir2); end
    or2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1) begin
        checks++; if (ir2 !== 1'b0) begin errors++; $display("FAIL cap_ir_e1 got %b exp 0", ir2); end
      end
      if (i == 2) begin
        checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL cap_ir_e2 got %b exp 1", ir2); end
      end
      if (ov2) begin
        checks++; if (od2 !== 32'(n + 1)) begin errors++; $display("FAIL cap_order[%0d] got %h exp %h", n, od2, n + 1); end
        n++;
      end
      step();
    end
    checks++; if (n != 4) begin errors++; $display("FAIL cap_drained got %0d exp 4", n); end
    checks++; if (cnt2 !== 3'd0) begin errors++; $display("FAIL cap_cnt_end got %0d exp 0", cnt2); end
  endtask

  task automatic test_flush();
    int seen = 0;
    or2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv2 = 1'b1;
      id2 = 32'hA1 + 32'(i);
      step();
    end
    checks++; if (cnt2 !== 3'd3) begin errors++; $display("FAIL flush_pre_cnt got %0d exp 3", cnt2); end
    id2 = 32'hAA;
    f2 = 1'b1;
    step();
    f2 = 1'b0;
    iv2 = 1'b0;
    checks++; if (cnt2 !== 3'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", cnt2); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL flush_ov got %b exp 0", ov2); end
    checks++; if (ir2 !== 1'b1) begin errors++; $display("FAIL flush_ir got %b exp 1", ir2); end
    or2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (ov2) seen++;
      step();
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL flush_leak got %0d exp 0", seen); end
  endtask

  task automatic test_async_reset();
    or2 = 1'b0;
    iv2 = 1'b1; id2 = 32'hB1; step();
    id2 = 32'hB2; step();
    iv2 = 1'b0;
    checks++; if (cnt2 !== 3'd2) begin errors++; $display("FAIL areset_pre_cnt got %0d exp 2", cnt2); end
    #2 rst = 1'b0;
    #1;
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL areset_ov got %b exp 0", ov2); end
    checks++; if (cnt2 !== 3'd0) begin errors++; $display("FAIL areset_cnt got %0d exp 0", cnt2); end
    checks++; if (od2 !== 32'h0) begin errors++; $display("FAIL areset_od got %h exp 0", od2); end
    iv2 = 1'b1; id2 = 32'hC1; or2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (cnt2 !== 3'd0) begin errors++; $display("FAIL areset_hold_cnt got %0d exp 0", cnt2); end
    checks++; if (ov2 !== 1'b0) begin errors++; $display("FAIL areset_hold_ov got %b exp 0", ov2); end
    iv2 = 1'b0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic       inf, outf;
    for (int c = 0; c < 10000; c++) begin
      checks++; if (int'(cnt3) != q.size()) begin errors++; $display("FAIL rnd_cnt cyc %0d got %0d exp %0d", c, cnt3, q.size()); end
      checks++; if (cnt3 > 3'd6) begin errors++; $display("FAIL rnd_cap cyc %0d got %0d exp <=6", c, cnt3); end
      if (ov3 === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_spurious cyc %0d got %h exp none", c, od3);
        end else if (od3 !== q[0]) begin
          errors++; $display("FAIL rnd_data cyc %0d got %h exp %h", c, od3, q[0]);
        end
      end
      iv3 = ($urandom_range(0, 99) < 60);
      id3 = 8'($urandom);
      or3 = ($urandom_range(0, 99) < 55);
      f3  = ($urandom_range(0, 99) < 3);
      inf  = iv3 & ir3;
      outf = ov3 & or3;
      if (outf && q.size() > 0) void'(q.pop_front());
      if (f3) q.delete();
      else if (inf) q.push_back(id3);
      step();
    end
    iv3 = 1'b0; f3 = 1'b0; or3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_capacity();
    test_flush();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
